// File: rtl/shf_share_arb.sv
// Two-requester round-robin arbiter in front of one logical right shifter with sticky.
// One registered result slot; accepts whenever the slot is empty or draining.
module shf_share_arb #(
   parameter int SIZE_DATA  = 24,
   parameter int SIZE_SHIFT = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid0,
   output logic                  o_ready0,
   input  logic [SIZE_DATA-1:0]  i_data0,
   input  logic [SIZE_SHIFT-1:0] i_shift_number0,
   input  logic                  i_valid1,
   output logic                  o_ready1,
   input  logic [SIZE_DATA-1:0]  i_data1,
   input  logic [SIZE_SHIFT-1:0] i_shift_number1,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [SIZE_DATA-1:0]  o_data,
   output logic                  o_sticky,
   output logic                  o_tag
);

   // Padding below the operand is as wide as the largest shift, so no shifted-out bit is lost.
   localparam int PAD_W = 1 << SIZE_SHIFT;
   localparam int EXT_W = SIZE_DATA + PAD_W;

   // Returns {sticky, shifted}; amounts >= SIZE_DATA naturally give zero data.
   function automatic logic [SIZE_DATA:0] shift_sticky(
      input logic [SIZE_DATA-1:0]  data,
      input logic [SIZE_SHIFT-1:0] amt
   );
      logic [EXT_W-1:0] ext;
      ext = {data, {PAD_W{1'b0}}} >> amt;
      return {|ext[PAD_W-1:0], ext[EXT_W-1 -: SIZE_DATA]};
   endfunction

   logic                  valid_q,  valid_d;
   logic [SIZE_DATA-1:0]  data_q,   data_d;
   logic                  sticky_q, sticky_d;
   logic                  tag_q,    tag_d;
   logic                  ptr_q,    ptr_d;

   logic                  can_acc;
   logic                  both_vld;
   logic                  grant0, grant1;
   logic                  rdy0, rdy1;
   logic [SIZE_DATA-1:0]  sel_data;
   logic [SIZE_SHIFT-1:0] sel_shift;
   logic [SIZE_DATA:0]    shf_res;

   // Grant and shift (combinational)
   always_comb begin
      can_acc   = ~valid_q | i_ready;
      both_vld  = i_valid0 & i_valid1;
      grant0    = i_valid0 & (~i_valid1 | ~ptr_q);
      grant1    = i_valid1 & (~i_valid0 |  ptr_q);
      rdy0      = grant0 & can_acc & ~i_rst;
      rdy1      = grant1 & can_acc & ~i_rst;
      sel_data  = rdy1 ? i_data1 : i_data0;
      sel_shift = rdy1 ? i_shift_number1 : i_shift_number0;
      shf_res   = shift_sticky(sel_data, sel_shift);
   end

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      sticky_d = sticky_q;
      tag_d    = tag_q;
      ptr_d    = ptr_q;
      if (rdy0 | rdy1) begin
         valid_d  = 1'b1;
         data_d   = shf_res[SIZE_DATA-1:0];
         sticky_d = shf_res[SIZE_DATA];
         tag_d    = rdy1;
         if (both_vld) begin
            ptr_d = ~rdy1;
         end
      end else if (valid_q & i_ready) begin
         valid_d = 1'b0;
      end
   end

   // Result register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         sticky_q <= 1'b0;
         tag_q    <= 1'b0;
         ptr_q    <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         sticky_q <= sticky_d;
         tag_q    <= tag_d;
         ptr_q    <= ptr_d;
      end
   end

   assign o_ready0 = rdy0;
   assign o_ready1 = rdy1;
   assign o_valid  = valid_q;
   assign o_data   = data_q;
   assign o_sticky = sticky_q;
   assign o_tag    = tag_q;

endmodule

// File: tb/tb_shf_share_arb.sv
// Bench for shf_share_arb: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_shf_share_arb;

   localparam int DW = 24;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          v0, v1, rdy0, rdy1;
   logic [DW-1:0] d0, d1;
   logic [SW-1:0] s0, s1;
   logic          ovld, ordy, osticky, otag;
   logic [DW-1:0] odata;

   int errors = 0;
   int checks = 0;

   shf_share_arb #(.SIZE_DATA(DW), .SIZE_SHIFT(SW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_valid0(v0), .o_ready0(rdy0), .i_data0(d0), .i_shift_number0(s0),
      .i_valid1(v1), .o_ready1(rdy1), .i_data1(d1), .i_shift_number1(s1),
      .o_valid(ovld), .i_ready(ordy), .o_data(odata), .o_sticky(osticky), .o_tag(otag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference shifter: shift one bit at a time, collecting what falls off.
   function automatic void ref_shift(input logic [DW-1:0] d, input int sh,
                                     output logic [DW-1:0] r, output logic s);
      r = d;
      s = 1'b0;
      for (int i = 0; i < sh; i++) begin
         s = s | r[0];
         r = r >> 1;
      end
   endfunction

   // Model state: one result slot plus the round-robin pointer.
   logic          m_ok = 1'b0;
   logic          m_valid, m_sticky, m_tag, m_ptr;
   logic [DW-1:0] m_data;
   logic          last_rdy0 = 1'b0, last_rdy1 = 1'b0;

   // Which requester the rules say is accepted now: -1 none, else 0/1.
   function automatic int who_wins();
      if (rst) return -1;
      if (m_valid && !ordy) return -1;
      if (v0 && v1) return m_ptr ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      int w;
      if (rst) begin
         m_ok = 1'b1; m_valid = 1'b0; m_data = '0; m_sticky = 1'b0; m_tag = 1'b0; m_ptr = 1'b0;
      end else if (m_ok) begin
         w = who_wins();
         if (w >= 0) begin
            if (w == 0) ref_shift(d0, int'(s0), m_data, m_sticky);
            else        ref_shift(d1, int'(s1), m_data, m_sticky);
            m_tag   = (w == 1);
            m_valid = 1'b1;
            if (v0 && v1) m_ptr = (w == 0);
         end else if (m_valid && ordy) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int w;
      if (m_ok) begin
         w = who_wins();
         chk("ready0", 32'(rdy0), 32'(w == 0));
         chk("ready1", 32'(rdy1), 32'(w == 1));
         chk("valid",  32'(ovld), 32'(m_valid));
         chk("data",   32'(odata), 32'(m_data));
         chk("sticky", 32'(osticky), 32'(m_sticky));
         chk("tag",    32'(otag), 32'(m_tag));
      end
      last_rdy0 = rdy0;
      last_rdy1 = rdy1;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   function automatic logic [SW-1:0] rand_shift();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return '0;
      if (r < 3)  return SW'($urandom_range(DW, (1 << SW) - 1));
      return SW'($urandom_range(1, DW - 1));
   endfunction

   function automatic logic [DW-1:0] rand_data();
      if ($urandom_range(0, 7) == 0) return '0;
      return DW'($urandom());
   endfunction

   initial begin
      int n0, n1;
      rst = 1'b1; v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
      d0 = 24'h111111; s0 = 5'd3; d1 = 24'h222222; s1 = 5'd4;

      // Reset with both requesters asking
      neg();
      chk("rst_ready0", 32'(rdy0), 32'd0);
      chk("rst_ready1", 32'(rdy1), 32'd0);
      step();
      neg();
      chk("rst_valid", 32'(ovld), 32'd0);
      chk("rst_data",  32'(odata), 32'd0);
      chk("rst_tag",   32'(otag), 32'd0);

      // Single shift from requester 0
      step();
      rst = 1'b0; v0 = 1'b1; d0 = 24'h800001; s0 = 5'd1; v1 = 1'b0;
      neg();
      chk("t2_ready0", 32'(rdy0), 32'd1);
      step();
      v0 = 1'b0;
      neg();
      chk("t2_valid",  32'(ovld), 32'd1);
      chk("t2_data",   32'(odata), 32'h400000);
      chk("t2_sticky", 32'(osticky), 32'd1);
      chk("t2_tag",    32'(otag), 32'd0);

      // Saturating shift from requester 1, non-zero then zero operand
      step();
      v1 = 1'b1; d1 = 24'h000100; s1 = 5'd31;
      neg();
      chk("t3_ready1", 32'(rdy1), 32'd1);
      step();
      d1 = 24'h000000; s1 = 5'd31;
      neg();
      chk("t3_data",   32'(odata), 32'd0);
      chk("t3_sticky", 32'(osticky), 32'd1);
      chk("t3_tag",    32'(otag), 32'd1);
      step();
      v1 = 1'b0;
      neg();
      chk("t3_data0",   32'(odata), 32'd0);
      chk("t3_sticky0", 32'(osticky), 32'd0);
      chk("t3_tag0",    32'(otag), 32'd1);

      // Tie fairness over four cycles
      step();
      v0 = 1'b1; v1 = 1'b1; ordy = 1'b1; d0 = 24'hABCDEF; s0 = 5'd2; d1 = 24'h135790; s1 = 5'd5;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 4; k++) begin
         neg();
         if (k > 0) chk("t4_tag", 32'(otag), 32'((k - 1) % 2));
         chk("t4_ready0", 32'(rdy0), 32'(k % 2 == 0));
         if (rdy0) n0++;
         if (rdy1) n1++;
         step();
      end
      v0 = 1'b0; v1 = 1'b0;
      neg();
      chk("t4_tag_last", 32'(otag), 32'd1);
      chk("t4_count0", 32'(n0), 32'd2);
      chk("t4_count1", 32'(n1), 32'd2);

      // Backpressure, then drain and refill together
      step();
      v0 = 1'b1; d0 = 24'h00F0F0; s0 = 5'd4; ordy = 1'b1;
      step();
      ordy = 1'b0; d0 = 24'h123456; s0 = 5'd0; v1 = 1'b1; d1 = 24'h0ABCDE; s1 = 5'd8;
      for (int k = 0; k < 3; k++) begin
         neg();
         chk("t5_stall_ready0", 32'(rdy0), 32'd0);
         chk("t5_stall_ready1", 32'(rdy1), 32'd0);
         chk("t5_stall_valid",  32'(ovld), 32'd1);
         chk("t5_stall_data",   32'(odata), 32'h000F0F);
         chk("t5_stall_sticky", 32'(osticky), 32'd0);
         step();
      end
      ordy = 1'b1;
      neg();
      chk("t5_refill_ready0", 32'(rdy0), 32'd1);
      chk("t5_refill_ready1", 32'(rdy1), 32'd0);
      step();
      v0 = 1'b0;
      neg();
      chk("t5_nobubble_valid", 32'(ovld), 32'd1);
      chk("t5_data",   32'(odata), 32'h123456);
      chk("t5_sticky", 32'(osticky), 32'd0);
      chk("t5_tag",    32'(otag), 32'd0);
      step();
      v1 = 1'b0;
      neg();
      chk("t5_data1",   32'(odata), 32'h000ABC);
      chk("t5_sticky1", 32'(osticky), 32'd1);
      chk("t5_tag1",    32'(otag), 32'd1);

      // Reset during a stall; pointer returns to requester 0
      step();
      v0 = 1'b1; d0 = 24'h000FFF; s0 = 5'd4; ordy = 1'b1;
      step();
      v0 = 1'b0; ordy = 1'b0;
      step();
      neg();
      chk("t6_held_valid",  32'(ovld), 32'd1);
      chk("t6_held_data",   32'(odata), 32'h0000FF);
      chk("t6_held_sticky", 32'(osticky), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; v0 = 1'b1; v1 = 1'b1; ordy = 1'b0;
      neg();
      chk("t6_valid", 32'(ovld), 32'd0);
      chk("t6_data",  32'(odata), 32'd0);
      chk("t6_ready0", 32'(rdy0), 32'd1);
      chk("t6_ready1", 32'(rdy1), 32'd0);
      step();
      v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;

      // Random traffic with requester hold protocol
      for (int c = 0; c < 4000; c++) begin
         step();
         rst = ($urandom_range(0, 199) == 0);
         if (!(v0 && !last_rdy0)) begin
            v0 = ($urandom_range(0, 99) < 60);
            d0 = rand_data();
            s0 = rand_shift();
         end
         if (!(v1 && !last_rdy1)) begin
            v1 = ($urandom_range(0, 99) < 60);
            d1 = rand_data();
            s1 = rand_shift();
         end
         ordy = ($urandom_range(0, 99) < 70);
      end
      step();
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
